// File: rtl/comparator_search_4bit.sv
// comparator_search_4bit
// Binary search for a hidden value. The block drives a probe (guess) into an
// external comparator and narrows lo/hi bounds from the comparator flags
// until it gets a match, runs out of candidates, or sees invalid flags.
module comparator_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             A_eq_B,
  input  logic             A_gt_B,
  input  logic             A_lt_B,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error,
  output logic [3:0]       probes
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_MID0 = {1'b0, {(WIDTH-1){1'b1}}};

  // Midpoint of two bounds; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [WIDTH-1:0] f_mid(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  // Comparator flags are only trusted when exactly one of them is set.
  function automatic logic f_flags_ok(input logic eq, input logic gt, input logic lt);
    logic ok;
    case ({eq, gt, lt})
      3'b100:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b001:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_guess;
  logic [WIDTH-1:0] r_result;
  logic             r_found;
  logic             r_error;
  logic [3:0]       r_probes;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_guess_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_found_nxt;
  logic             w_error_nxt;
  logic [3:0]       w_probes_nxt;
  logic [WIDTH-1:0] w_guess_dec;
  logic [WIDTH-1:0] w_guess_inc;
  logic             w_flags_ok;

  assign w_guess_dec = r_guess - C_ONE;
  assign w_guess_inc = r_guess + C_ONE;
  assign w_flags_ok  = f_flags_ok(A_eq_B, A_gt_B, A_lt_B);

  // Next-state and next-value logic; every value holds unless a branch changes it.
  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_guess_nxt  = r_guess;
    w_result_nxt = r_result;
    w_found_nxt  = r_found;
    w_error_nxt  = r_error;
    w_probes_nxt = r_probes;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_lo_nxt     = C_ZERO;
          w_hi_nxt     = C_MAX;
          w_guess_nxt  = C_MID0;
          w_probes_nxt = 4'd0;
          w_found_nxt  = 1'b0;
          w_error_nxt  = 1'b0;
          w_state_nxt  = SEARCH;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      SEARCH: begin
        w_probes_nxt = r_probes + 4'd1;
        if (!w_flags_ok) begin
          w_error_nxt = 1'b1;
          w_found_nxt = 1'b0;
          w_state_nxt = DONE;
        end else if (A_eq_B) begin
          w_result_nxt = r_guess;
          w_found_nxt  = 1'b1;
          w_state_nxt  = DONE;
        end else if (A_gt_B) begin
          // guess==lo with guess too big means no candidate is left below it.
          if (r_guess == r_lo) begin
            w_found_nxt = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_hi_nxt    = w_guess_dec;
            w_guess_nxt = f_mid(r_lo, w_guess_dec);
          end
        end else begin
          // Only A_lt_B can remain here; guess==hi means nothing above is left.
          if (r_guess == r_hi) begin
            w_found_nxt = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_lo_nxt    = w_guess_inc;
            w_guess_nxt = f_mid(w_guess_inc, r_hi);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lo     <= C_ZERO;
      r_hi     <= C_ZERO;
      r_guess  <= C_ZERO;
      r_result <= C_ZERO;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
      r_probes <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_guess  <= w_guess_nxt;
      r_result <= w_result_nxt;
      r_found  <= w_found_nxt;
      r_error  <= w_error_nxt;
      r_probes <= w_probes_nxt;
      r_busy   <= (w_state_nxt == SEARCH);
      r_done   <= (w_state_nxt == DONE);
    end
  end

  assign guess  = r_guess;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign found  = r_found;
  assign error  = r_error;
  assign probes = r_probes;

endmodule

// File: tb/tb_comparator_search_4bit.sv
// Directed bench for comparator_search_4bit with a behavioural comparator.
module tb_comparator_search_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       A_eq_B;
  logic       A_gt_B;
  logic       A_lt_B;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       found;
  logic       error;
  logic [3:0] probes;

  logic [3:0] target;
  logic       force_en;
  logic [2:0] force_flags;   // {eq, gt, lt}

  int n_checks;
  int n_errors;

  comparator_search_4bit #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A_eq_B (A_eq_B),
    .A_gt_B (A_gt_B),
    .A_lt_B (A_lt_B),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .error  (error),
    .probes (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator: guess is A, target is B; can be overridden.
  always_comb begin
    if (force_en) begin
      {A_eq_B, A_gt_B, A_lt_B} = force_flags;
    end else begin
      A_eq_B = (guess == target);
      A_gt_B = (guess > target);
      A_lt_B = (guess < target);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a search and follow it until done, logging each probed guess.
  task automatic do_search(input logic [3:0] tgt, output int lat, output int bcnt,
                           output logic [31:0] seq);
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat    = 1;
    bcnt   = 0;
    seq    = 32'h0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) begin
        seq  = {seq[27:0], guess};
        bcnt = bcnt + 1;
      end
      step();
      lat = lat + 1;
    end
    if (done !== 1'b1) check("search_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  int          bcnt;
  logic [31:0] seq;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    target      = 4'd0;
    force_en    = 1'b0;
    force_flags = 3'b000;
    step();
    step();
    check("rst_guess",  {28'd0, guess},  32'd0);
    check("rst_result", {28'd0, result}, 32'd0);
    check("rst_probes", {28'd0, probes}, 32'd0);
    check("rst_flags",  {28'd0, busy, done, found, error}, 32'd0);
    rst = 1'b0;
    step();
    step();
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    // target 7: single probe
    do_search(4'd7, lat, bcnt, seq);
    check("t7_seq",    seq, 32'h7);
    check("t7_probes", {28'd0, probes}, 32'd1);
    check("t7_found",  {31'd0, found},  32'd1);
    check("t7_result", {28'd0, result}, 32'd7);
    check("t7_lat",    lat, 32'd2);
    step();
    check("t7_done_pulse", {31'd0, done}, 32'd0);
    check("t7_hold_result", {28'd0, result}, 32'd7);

    // target 15: five probes
    do_search(4'd15, lat, bcnt, seq);
    check("t15_seq",    seq, 32'h7BDEF);
    check("t15_probes", {28'd0, probes}, 32'd5);
    check("t15_found",  {31'd0, found},  32'd1);
    check("t15_result", {28'd0, result}, 32'd15);
    check("t15_busy",   bcnt, 32'd5);
    check("t15_lat",    lat, 32'd6);
    // start during the done cycle must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_on_done", {31'd0, busy}, 32'd0);
    step();
    check("start_on_done2", {31'd0, busy}, 32'd0);
    check("t15_hold_probes", {28'd0, probes}, 32'd5);

    // target 0: four probes
    do_search(4'd0, lat, bcnt, seq);
    check("t0_seq",    seq, 32'h7310);
    check("t0_probes", {28'd0, probes}, 32'd4);
    check("t0_found",  {31'd0, found},  32'd1);
    check("t0_result", {28'd0, result}, 32'd0);
    step();

    // invalid flags on first probe
    force_en    = 1'b1;
    force_flags = 3'b000;
    do_search(4'd5, lat, bcnt, seq);
    check("err_error",  {31'd0, error}, 32'd1);
    check("err_found",  {31'd0, found}, 32'd0);
    check("err_probes", {28'd0, probes}, 32'd1);
    check("err_lat",    lat, 32'd2);
    step();
    check("err_done_pulse", {31'd0, done}, 32'd0);

    // always A_lt_B: runs off the top
    force_flags = 3'b001;
    do_search(4'd5, lat, bcnt, seq);
    check("lt_seq",    seq, 32'h7BDEF);
    check("lt_found",  {31'd0, found}, 32'd0);
    check("lt_error",  {31'd0, error}, 32'd0);
    check("lt_probes", {28'd0, probes}, 32'd5);
    step();
    force_en = 1'b0;

    // reset during the third probe of target 12
    target = 4'd12;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    check("r12_third_guess", {28'd0, guess}, 32'd13);
    rst = 1'b1;
    step();
    check("r12_guess",  {28'd0, guess},  32'd0);
    check("r12_result", {28'd0, result}, 32'd0);
    check("r12_probes", {28'd0, probes}, 32'd0);
    check("r12_flags",  {28'd0, busy, done, found, error}, 32'd0);
    rst = 1'b0;
    step();
    step();
    step();
    check("r12_idle", {27'd0, busy, guess}, 32'd0);

    // start re-pulsed mid-search (target 9: 7, 11, 9)
    target = 4'd9;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    check("mid_done",   {31'd0, done},   32'd1);
    check("mid_result", {28'd0, result}, 32'd9);
    check("mid_probes", {28'd0, probes}, 32'd3);
    step();
    step();
    check("mid_no_queue", {31'd0, busy}, 32'd0);

    // exhaustive targets
    for (int t = 0; t < 16; t++) begin
      do_search(t[3:0], lat, bcnt, seq);
      check("ex_found",  {31'd0, found}, 32'd1);
      check("ex_result", {28'd0, result}, t);
      check("ex_probes_le5", {31'd0, (probes <= 4'd5)}, 32'd1);
      check("ex_lat", lat, {28'd0, probes} + 32'd1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
